// File: rtl/jesd204b_rx_link_ctrl.sv
// JESD204B receive link controller.
// Sequences the SYNC~/SYSREF handshake for up to LANES lanes. It keeps a local
// LMFC counter aligned to SYSREF and holds SYNC~ low until code-group sync has
// been stable, then releases it on an LMFC boundary. It also supervises ILA
// completion and data-phase lane errors, and forces a resync when either fails.
module jesd204b_rx_link_ctrl #(
    parameter int LANES       = 4,
    parameter int LMFC_PERIOD = 8,
    parameter int CGS_HOLD    = 4,
    parameter int ILA_TIMEOUT = 8,
    parameter int ERR_THRESH  = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [LANES-1:0]               lane_mask,
    input  logic                           sysref_i,
    input  logic [LANES-1:0]               cgs_ok_i,
    input  logic [LANES-1:0]               ila_done_i,
    input  logic [LANES-1:0]               lane_err_i,
    input  logic                           clr_status,
    output logic [LANES-1:0]               sync_b_o,
    output logic [$clog2(LMFC_PERIOD)-1:0] lmfc_cnt_o,
    output logic                           lmfc_tick_o,
    output logic                           link_up_o,
    output logic [2:0]                     state_o,
    output logic                           sysref_misalign_o,
    output logic [7:0]                     resync_cnt_o
);

    localparam int CNT_W = $clog2(LMFC_PERIOD);
    localparam int CGS_W = $clog2(CGS_HOLD + 1);
    localparam int ILA_W = $clog2(ILA_TIMEOUT + 1);
    localparam int ERR_W = $clog2(ERR_THRESH + 1);

    localparam logic [CNT_W-1:0] LMFC_LAST = CNT_W'(LMFC_PERIOD - 1);
    localparam logic [CGS_W-1:0] CGS_LAST  = CGS_W'(CGS_HOLD - 1);
    localparam logic [ILA_W-1:0] ILA_LAST  = ILA_W'(ILA_TIMEOUT - 1);
    localparam logic [ERR_W-1:0] ERR_LAST  = ERR_W'(ERR_THRESH - 1);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_WAIT_SYSREF = 3'd1,
        ST_CGS         = 3'd2,
        ST_ILA         = 3'd3,
        ST_DATA        = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   lmfc_cnt_q, lmfc_cnt_d;
    logic               lmfc_tick_q, lmfc_tick_d;
    logic               sysref_prev_q, sysref_prev_d;
    logic [CGS_W-1:0]   cgs_cnt_q, cgs_cnt_d;
    logic [ILA_W-1:0]   ila_tmr_q, ila_tmr_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic [LANES-1:0]   sync_b_q, sync_b_d;
    logic               link_up_q, link_up_d;
    logic               misalign_q, misalign_d;
    logic [7:0]         resync_cnt_q, resync_cnt_d;

    logic               sysref_edge;
    logic               lmfc_tick;
    logic               resync_evt;
    logic               misalign_evt;

    // Unused lanes look permanently healthy so they never block or trip the link.
    logic [LANES-1:0]   lane_cgs_ok;
    logic [LANES-1:0]   lane_ila_done;
    logic [LANES-1:0]   lane_err_qual;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_cgs_ok[gi]   = cgs_ok_i[gi]   | ~lane_mask[gi];
            assign lane_ila_done[gi] = ila_done_i[gi] | ~lane_mask[gi];
            assign lane_err_qual[gi] = lane_err_i[gi] &  lane_mask[gi];
        end
    endgenerate

    logic all_cgs_ok;
    logic all_ila_done;
    logic any_lane_err;

    assign all_cgs_ok   = &lane_cgs_ok;
    assign all_ila_done = &lane_ila_done;
    assign any_lane_err = |lane_err_qual;

    // SYSREF edge detect and the LMFC phase counter. Realignment is allowed
    // only before the link is released. Afterwards the phase is frozen.
    always_comb begin
        sysref_prev_d = sysref_i;
        sysref_edge   = sysref_i & ~sysref_prev_q;
        lmfc_tick     = (lmfc_cnt_q == '0);
        if (sysref_edge && (state_q == ST_WAIT_SYSREF || state_q == ST_CGS)) begin
            lmfc_cnt_d = '0;
        end else if (lmfc_cnt_q == LMFC_LAST) begin
            lmfc_cnt_d = '0;
        end else begin
            lmfc_cnt_d = lmfc_cnt_q + 1'b1;
        end
        lmfc_tick_d = (lmfc_cnt_d == '0);
    end

    // Link state machine. Each counter defaults to zero, so it clears on any
    // state change and only holds or advances while its own state persists.
    always_comb begin
        state_d    = state_q;
        cgs_cnt_d  = '0;
        ila_tmr_d  = '0;
        err_cnt_d  = '0;
        resync_evt = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT_SYSREF;
                end
                ST_WAIT_SYSREF: begin
                    if (sysref_edge) begin
                        state_d = ST_CGS;
                    end
                end
                ST_CGS: begin
                    if (all_cgs_ok) begin
                        if (lmfc_tick) begin
                            if (cgs_cnt_q == CGS_LAST) begin
                                state_d = ST_ILA;
                            end else begin
                                cgs_cnt_d = cgs_cnt_q + 1'b1;
                            end
                        end else begin
                            cgs_cnt_d = cgs_cnt_q;
                        end
                    end
                end
                ST_ILA: begin
                    // All-done is checked first so it beats a coincident timeout.
                    if (all_ila_done) begin
                        state_d = ST_DATA;
                    end else if (lmfc_tick) begin
                        if (ila_tmr_q == ILA_LAST) begin
                            state_d    = ST_CGS;
                            resync_evt = 1'b1;
                        end else begin
                            ila_tmr_d = ila_tmr_q + 1'b1;
                        end
                    end else begin
                        ila_tmr_d = ila_tmr_q;
                    end
                end
                ST_DATA: begin
                    if (any_lane_err) begin
                        if (err_cnt_q == ERR_LAST) begin
                            state_d    = ST_CGS;
                            resync_evt = 1'b1;
                        end else begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                    end else begin
                        err_cnt_d = err_cnt_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        // SYNC~ follows the next state, so it moves on the same edge as the state.
        sync_b_d  = (state_d == ST_ILA || state_d == ST_DATA) ? {LANES{1'b1}} : ~lane_mask;
        link_up_d = (state_d == ST_DATA);
    end

    // Sticky status. A clear request overrides a coincident set or increment.
    always_comb begin
        misalign_evt = (state_q == ST_DATA) && sysref_edge && (lmfc_cnt_q != LMFC_LAST);
        if (clr_status) begin
            misalign_d = 1'b0;
        end else if (misalign_evt) begin
            misalign_d = 1'b1;
        end else begin
            misalign_d = misalign_q;
        end
        if (clr_status) begin
            resync_cnt_d = '0;
        end else if (resync_evt && resync_cnt_q != 8'hFF) begin
            resync_cnt_d = resync_cnt_q + 8'd1;
        end else begin
            resync_cnt_d = resync_cnt_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            lmfc_cnt_q    <= '0;
            lmfc_tick_q   <= 1'b0;
            sysref_prev_q <= 1'b0;
            cgs_cnt_q     <= '0;
            ila_tmr_q     <= '0;
            err_cnt_q     <= '0;
            sync_b_q      <= '0;
            link_up_q     <= 1'b0;
            misalign_q    <= 1'b0;
            resync_cnt_q  <= '0;
        end else begin
            state_q       <= state_d;
            lmfc_cnt_q    <= lmfc_cnt_d;
            lmfc_tick_q   <= lmfc_tick_d;
            sysref_prev_q <= sysref_prev_d;
            cgs_cnt_q     <= cgs_cnt_d;
            ila_tmr_q     <= ila_tmr_d;
            err_cnt_q     <= err_cnt_d;
            sync_b_q      <= sync_b_d;
            link_up_q     <= link_up_d;
            misalign_q    <= misalign_d;
            resync_cnt_q  <= resync_cnt_d;
        end
    end

    assign sync_b_o          = sync_b_q;
    assign lmfc_cnt_o        = lmfc_cnt_q;
    assign lmfc_tick_o       = lmfc_tick_q;
    assign link_up_o         = link_up_q;
    assign state_o           = state_q;
    assign sysref_misalign_o = misalign_q;
    assign resync_cnt_o      = resync_cnt_q;

endmodule

// File: tb/tb_jesd204b_rx_link_ctrl.sv
// Testbench for jesd204b_rx_link_ctrl. Directed bring-up, alignment, glitch,
// mask, timeout, error and reset scenarios are followed by random traffic and a
// saturation run. A behavioural link model predicts every output on every cycle.
module tb_jesd204b_rx_link_ctrl;
    localparam int LANES = 4;
    localparam int P     = 8;
    localparam int HOLD  = 2;
    localparam int TO    = 4;
    localparam int TH    = 3;

    logic       clk = 1'b0;
    logic       reset, enable, sysref_i, clr_status;
    logic [3:0] lane_mask, cgs_ok_i, ila_done_i, lane_err_i;
    logic [3:0] sync_b_o;
    logic [2:0] lmfc_cnt_o;
    logic       lmfc_tick_o, link_up_o, sysref_misalign_o;
    logic [2:0] state_o;
    logic [7:0] resync_cnt_o;

    int checks = 0;
    int errors = 0;
    int n, norm;

    // Reference model state: link phase, LMFC phase, progress counters and status.
    int         ms, mc, mt, mp, mcg, mil, mer, mlu, mmis, mrs;
    logic [3:0] msb;

    always #5 clk = ~clk;

    jesd204b_rx_link_ctrl #(
        .LANES(LANES), .LMFC_PERIOD(P), .CGS_HOLD(HOLD),
        .ILA_TIMEOUT(TO), .ERR_THRESH(TH)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .lane_mask(lane_mask),
        .sysref_i(sysref_i), .cgs_ok_i(cgs_ok_i), .ila_done_i(ila_done_i),
        .lane_err_i(lane_err_i), .clr_status(clr_status), .sync_b_o(sync_b_o),
        .lmfc_cnt_o(lmfc_cnt_o), .lmfc_tick_o(lmfc_tick_o), .link_up_o(link_up_o),
        .state_o(state_o), .sysref_misalign_o(sysref_misalign_o),
        .resync_cnt_o(resync_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        ms = 0; mc = 0; mt = 0; mp = 0; mcg = 0; mil = 0; mer = 0;
        mlu = 0; mmis = 0; mrs = 0; msb = 4'h0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        int  ns, ncg, nil, ner, nc;
        bit  sr_edge, at_tick, allok, alldone, anyerr, rsev, misev;
        sr_edge = (sysref_i == 1'b1) && (mp == 0);
        at_tick = (mc == 0);
        allok   = ((cgs_ok_i | ~lane_mask) == 4'hF);
        alldone = ((ila_done_i | ~lane_mask) == 4'hF);
        anyerr  = ((lane_err_i & lane_mask) != 4'h0);
        ns = ms; ncg = 0; nil = 0; ner = 0; rsev = 0;
        if (!enable) ns = 0;
        else if (ms == 0) ns = 1;
        else if (ms == 1) begin
            if (sr_edge) ns = 2;
        end else if (ms == 2) begin
            if (allok && at_tick && mcg == HOLD - 1) ns = 3;
            else if (allok) ncg = mcg + (at_tick ? 1 : 0);
        end else if (ms == 3) begin
            if (alldone) ns = 4;
            else if (at_tick && mil + 1 == TO) begin ns = 2; rsev = 1; end
            else nil = mil + (at_tick ? 1 : 0);
        end else begin
            if (anyerr && mer + 1 == TH) begin ns = 2; rsev = 1; end
            else ner = mer + (anyerr ? 1 : 0);
        end
        misev = (ms == 4) && sr_edge && (mc != P - 1);
        nc = (sr_edge && (ms == 1 || ms == 2)) ? 0 : (mc + 1) % P;
        if (clr_status) begin mmis = 0; mrs = 0; end
        else begin
            if (misev) mmis = 1;
            if (rsev && mrs < 255) mrs = mrs + 1;
        end
        ms = ns; mc = nc; mt = (nc == 0) ? 1 : 0; mp = sysref_i ? 1 : 0;
        mcg = ncg; mil = nil; mer = ner;
        msb = (ns == 3 || ns == 4) ? 4'hF : ~lane_mask;
        mlu = (ns == 4) ? 1 : 0;
    endtask

    task automatic compare_all();
        check("sync_b",   sync_b_o,          msb);
        check("lmfc_cnt", lmfc_cnt_o,        mc);
        check("lmfc_tick", lmfc_tick_o,      mt);
        check("link_up",  link_up_o,         mlu);
        check("state",    state_o,           ms);
        check("misalign", sysref_misalign_o, mmis);
        check("resync",   resync_cnt_o,      mrs);
    endtask

    // One clock: predict, let the edge pass, compare on the falling edge.
    task automatic cycle();
        int prev_s;
        prev_s = ms;
        model_step();
        if (ms == 4 && prev_s != 4)
            $display("t=%0t link up, mask %h, resync count %0d", $time, lane_mask, mrs);
        else if (ms == 2 && prev_s >= 3)
            $display("t=%0t resync from state %0d, resync count %0d", $time, prev_s, mrs);
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_state(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (ms != target && k < budget) begin cycle(); k++; end
        check(tag, state_o, target);
    endtask

    task automatic wait_cnt(input int target);
        int k;
        k = 0;
        while (mc != target && k < 2 * P) begin cycle(); k++; end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; lane_mask = 4'h0; sysref_i = 1'b0;
        cgs_ok_i = 4'h0; ila_done_i = 4'h0; lane_err_i = 4'h0; clr_status = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        reset = 1'b0;

        // Bring-up with SYSREF arriving at LMFC phase 5.
        enable = 1'b1; lane_mask = 4'hF; cgs_ok_i = 4'hF;
        cycle();
        wait_cnt(5);
        check("wait_sysref_state", state_o, 1);
        sysref_i = 1'b1; cycle(); sysref_i = 1'b0;
        check("realign_cnt", lmfc_cnt_o, 0);
        check("cgs_entry", state_o, 2);
        norm = 0;
        while (ms == 2 && norm < 64) begin cycle(); norm++; end
        check("release_sync_b", sync_b_o, 4'hF);
        repeat (20) cycle();
        ila_done_i = 4'hF;
        wait_state(4, 40, "bringup_data");
        check("bringup_link_up", link_up_o, 1);

        // SYSREF in DATA: off-phase edge flags, end-of-multiframe edge does not.
        wait_cnt(3);
        sysref_i = 1'b1; cycle(); sysref_i = 1'b0;
        check("misalign_at_3", sysref_misalign_o, 1);
        clr_status = 1'b1; cycle(); clr_status = 1'b0;
        check("misalign_cleared", sysref_misalign_o, 0);
        wait_cnt(7);
        sysref_i = 1'b1; cycle(); sysref_i = 1'b0;
        check("aligned_no_flag", sysref_misalign_o, 0);

        // CGS glitch on lane 2 costs exactly one more LMFC period.
        ila_done_i = 4'h0;
        enable = 1'b0; cycle(); enable = 1'b1; cycle();
        wait_cnt(2);
        sysref_i = 1'b1; cycle(); sysref_i = 1'b0;
        n = 0;
        cycle(); n++;
        cgs_ok_i = 4'b1011; cycle(); n++; cgs_ok_i = 4'hF;
        while (ms == 2 && n < 64) begin cycle(); n++; end
        check("glitch_delay", n, norm + P);

        // ILA timeout, then error-driven resync.
        wait_state(2, 48, "ila_timeout");
        check("timeout_resync", resync_cnt_o, 1);
        ila_done_i = 4'hF;
        wait_state(4, 64, "data_after_timeout");
        lane_err_i = 4'b0100;
        repeat (TH) cycle();
        lane_err_i = 4'h0;
        check("err_resync_state", state_o, 2);
        check("err_resync_sync_b", sync_b_o, 4'h0);
        check("err_resync_cnt", resync_cnt_o, 2);

        // Disable from CGS, then clear status.
        enable = 1'b0; cycle();
        check("disable_idle", state_o, 0);
        clr_status = 1'b1; cycle(); clr_status = 1'b0;
        check("clr_resync", resync_cnt_o, 0);

        // Lane 3 unused.
        lane_mask = 4'b0111; cgs_ok_i = 4'b0111; ila_done_i = 4'b0111;
        enable = 1'b1; cycle(); cycle();
        sysref_i = 1'b1; cycle(); sysref_i = 1'b0;
        check("mask_cgs_sync_b", sync_b_o, 4'b1000);
        wait_state(4, 64, "mask_data");
        check("mask_link_up", link_up_o, 1);

        // Asynchronous reset in DATA, observed before any clock edge.
        #2 reset = 1'b1;
        #1;
        check("arst_sync_b", sync_b_o, 0);
        check("arst_state", state_o, 0);
        check("arst_link_up", link_up_o, 0);
        check("arst_cnt", lmfc_cnt_o, 0);
        check("arst_tick", lmfc_tick_o, 0);
        check("arst_resync", resync_cnt_o, 0);
        check("arst_misalign", sysref_misalign_o, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0; lane_mask = 4'hF;
        compare_all();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 199) == 0) lane_mask = 4'($urandom);
            sysref_i   = ($urandom_range(0, 11) == 0);
            cgs_ok_i   = ($urandom_range(0, 39) == 0) ? 4'($urandom) : (lane_mask | 4'($urandom));
            ila_done_i = ($urandom_range(0, 24) == 0) ? (lane_mask | 4'($urandom))
                                                      : 4'($urandom & $urandom);
            lane_err_i = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
            clr_status = ($urandom_range(0, 49) == 0);
            cycle();
        end

        // Forced resyncs until the counter saturates.
        enable = 1'b1; lane_mask = 4'hF; cgs_ok_i = 4'hF; ila_done_i = 4'hF;
        lane_err_i = 4'hF; clr_status = 1'b0;
        n = 0;
        while (mrs < 255 && n < 12000) begin
            sysref_i = (n % 16 == 0);
            cycle(); n++;
        end
        sysref_i = 1'b0;
        repeat (100) cycle();
        check("resync_saturated", resync_cnt_o, 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
